// File: rtl/booth_mult_32.sv
// Radix-2 Booth multicycle signed multiplier for the execute stage.
// One add/subtract of the multiplicand and one arithmetic right shift per clock.
// The result is written back through the shared result mux, qualified by a one-cycle ready pulse.
module booth_mult_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // The accumulator is WIDTH+1 bits so that subtracting the most-negative multiplicand cannot wrap.
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH:0]   hi_bits;
    logic             ovf;

    // One Booth step: add or subtract M according to {Q[0], q_1}, then shift the whole of P right arithmetically.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m_reg;
            2'b10:   sum = acc - m_reg;
            default: sum = acc;
        endcase
        acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        // The product fits in WIDTH signed bits only when bits [2W-1:W-1] all equal the sign bit.
        hi_bits = {acc_nxt[WIDTH-1:0], q_nxt[WIDTH-1]};
        ovf     = !((&hi_bits) || (~|hi_bits));
    end

    // Control FSM and datapath registers. A start pulse in any state restarts the operation with fresh operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            m_reg          <= '0;
            acc            <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            if (ctrl_mult) begin
                state <= RUN;
                count <= '0;
                m_reg <= {data_operandA[WIDTH-1], data_operandA};
                acc   <= '0;
                q     <= data_operandB;
                q_1   <= 1'b0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        acc   <= acc_nxt;
                        q     <= q_nxt;
                        q_1   <= q[0];
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_result    <= q_nxt;
                            data_exception <= ovf;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_32.sv
// Bench for booth_mult_32: directed corner cases plus randomized operations with random aborts,
// checked every cycle against a transaction-level model built on 64-bit signed multiplication.
module tb_booth_mult_32;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ctrl_mult = 1'b0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rdy_count = 0;
    bit chk_en = 1'b0;

    booth_mult_32 #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: a start computes the full signed product and schedules
    // its completion W clocks later; a new start or reset discards the pending one.
    logic signed [63:0] sa, sb;
    assign sa = {{32{data_operandA[W-1]}}, data_operandA};
    assign sb = {{32{data_operandB[W-1]}}, data_operandB};

    logic signed [63:0] m_prod = '0;
    int                 m_left = 0;
    bit                 m_active = 1'b0;
    logic               m_rdy = 1'b0, m_exc = 1'b0, m_busy = 1'b0;
    logic [W-1:0]       m_res = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0; m_left <= 0; m_rdy <= 1'b0; m_exc <= 1'b0;
            m_res <= '0; m_busy <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            m_exc <= 1'b0;
            if (ctrl_mult) begin
                m_prod   <= sa * sb;
                m_left   <= W;
                m_active <= 1'b1;
                m_busy   <= 1'b1;
            end else if (m_active) begin
                if (m_left == 1) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                    m_rdy    <= 1'b1;
                    m_res    <= m_prod[W-1:0];
                    m_exc    <= (m_prod != {{32{m_prod[W-1]}}, m_prod[W-1:0]});
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("rdy",    64'(data_resultRDY), 64'(m_rdy));
            check("busy",   64'(busy),           64'(m_busy));
            check("result", 64'(data_result),    64'(m_res));
            check("exc",    64'(data_exception), 64'(m_exc));
            if (data_resultRDY) rdy_count++;
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts cycles from the current point until the ready pulse is seen, with a bound.
    task automatic wait_rdy(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!data_resultRDY && lat < 60);
        if (!data_resultRDY) check("rdy_timeout", 64'(lat), 64'(0));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ee);
        int lat;
        start(a, b);
        wait_rdy(lat);
        check({name, "_lat"}, 64'(lat), 64'(32));
        check({name, "_res"}, 64'(data_result), 64'(er));
        check({name, "_exc"}, 64'(data_exception), 64'(ee));
        check({name, "_model"}, 64'({m_res, m_exc}), 64'({er, ee}));
    endtask

    initial begin
        int lat, rc;
        reset_n = 1'b0;
        repeat (3) tick();
        check("reset_res",  64'(data_result), 64'(0));
        check("reset_rdy",  64'(data_resultRDY), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_exc",  64'(data_exception), 64'(0));
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick();

        run_op("t1", 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0);
        tick();
        run_op("t2", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        run_op("t3a", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("t3b", 32'h8000_0000, 32'h1, 32'h8000_0000, 1'b0);
        check("t3b_hold", 64'(data_result), 64'(32'h8000_0000));

        // Abort: restart at step 10 with new operands; only one ready pulse.
        rc = rdy_count;
        start(32'd5, 32'd6);
        repeat (9) tick();
        run_op("t4", 32'd7, 32'd8, 32'd56, 1'b0);
        tick();
        check("t4_pulses", 64'(rdy_count - rc), 64'(1));

        // Reset mid-operation clears outputs immediately and kills the pending result.
        start(32'h7FFF_FFFF, 32'd2);
        repeat (14) tick();
        reset_n = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_res",  64'(data_result), 64'(0));
        tick();
        reset_n = 1'b1;
        rc = rdy_count;
        repeat (40) tick();
        check("t5_norpdy", 64'(rdy_count - rc), 64'(0));
        run_op("t5b", 32'd2, 32'd2, 32'd4, 1'b0);

        // Back-to-back: start a new op in the DONE cycle.
        start(32'd9, 32'd9);
        wait_rdy(lat);
        check("t6_res", 64'(data_result), 64'(81));
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        lat = 1;
        while (!data_resultRDY && lat < 60) begin
            tick();
            lat++;
        end
        check("t6_gap", 64'(lat), 64'(33));
        check("t6_res2", 64'(data_result), 64'(12));

        // Randomized operations with occasional aborts; corner operands mixed in.
        for (int n = 0; n < 1800; n++) begin
            logic [W-1:0] a, b;
            logic [W-1:0] corner [5];
            int ab;
            corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF;
            corner[2] = 32'h0; corner[3] = 32'h1; corner[4] = 32'hFFFF_FFFF;
            a = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($signed(16'($urandom)));
            start(a, b);
            if ($urandom_range(0, 9) == 0) begin
                ab = $urandom_range(0, 30);
                repeat (ab) tick();
                start(W'($urandom), W'($urandom));
            end
            wait_rdy(lat);
            if ($urandom_range(0, 1) == 0) tick();
        end

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
